// File: rtl/data_mem_unit.sv
// Byte-addressable data memory for the load/store stage: valid/ready request side,
// byte/half/word accesses with lane writes, extended loads and a fixed-latency response.
module data_mem_unit #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err
);

   localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
   localparam int CW    = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] LAST     = CW'(LATENCY);
   localparam logic [CW-1:0] PRE_LAST = CW'(LATENCY - 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                  state;
   logic                    busy;
   logic [CW-1:0]           cnt;
   logic [31:0]             mem [WORDS];
   logic [ADDR_WIDTH-3:0]   word_idx;
   logic [1:0]              lane;
   logic                    accept;
   logic                    err;
   logic [31:0]             rd_word;
   logic [7:0]              rd_byte;
   logic [15:0]             rd_half;
   logic [31:0]             load_val;
   logic [31:0]             wr_data;
   logic [3:0]              wr_be;
   logic [31:0]             pipe_data;
   logic                    pipe_err;

   assign busy      = (state == WAIT);
   assign req_ready = !rst && (!busy || rsp_valid);
   assign accept    = req_valid && req_ready;
   assign word_idx  = req_addr[ADDR_WIDTH-1:2];
   assign lane      = req_addr[1:0];
   assign rd_word   = mem[word_idx];

   // Decode: alignment check, lane extraction/extension for loads, lane enables for stores.
   always_comb begin
      err      = (req_size == 2'b11) ||
                 (req_size == 2'b01 && lane[0]) ||
                 (req_size == 2'b10 && lane != 2'b00);
      rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
      rd_byte  = rd_word[7:0];
      case (lane)
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         2'd3:    rd_byte = rd_word[31:24];
         default: rd_byte = rd_word[7:0];
      endcase
      load_val = '0;
      if (!req_we && !err) begin
         case (req_size)
            2'b00:   load_val = {{24{!req_unsigned && rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{!req_unsigned && rd_half[15]}}, rd_half};
            2'b10:   load_val = rd_word;
            default: load_val = '0;
         endcase
      end
      wr_data = req_wdata;
      wr_be   = 4'b1111;
      case (req_size)
         2'b00: begin
            wr_data = {4{req_wdata[7:0]}};
            wr_be   = 4'b0001 << lane;
         end
         2'b01: begin
            wr_data = {2{req_wdata[15:0]}};
            wr_be   = lane[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wr_data = req_wdata;
            wr_be   = 4'b1111;
         end
      endcase
   end

   // Storage is deliberately left without reset; stores land at their acceptance edge.
   always_ff @(posedge clk) begin
      if (accept && req_we && !err) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // Response sequencer: the response registers load on the edge that makes cnt reach LATENCY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         pipe_data <= '0;
         pipe_err  <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         if (accept) begin
            state     <= WAIT;
            cnt       <= CW'(1);
            pipe_data <= load_val;
            pipe_err  <= err;
            if (LATENCY == 1) begin
               rsp_valid <= 1'b1;
               rsp_rdata <= load_val;
               rsp_err   <= err;
            end
         end else if (busy) begin
            if (cnt == LAST) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
               if (cnt == PRE_LAST) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= pipe_data;
                  rsp_err   <= pipe_err;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: one instance at LATENCY=1 and one at LATENCY=3,
// directed scenarios plus random traffic against a byte-array reference model.
module tb_data_mem_unit;

   localparam int AW = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid    [2];
   logic        req_ready    [2];
   logic        req_we       [2];
   logic [1:0]  req_size     [2];
   logic        req_unsigned [2];
   logic [AW-1:0] req_addr   [2];
   logic [31:0] req_wdata    [2];
   logic        rsp_valid    [2];
   logic [31:0] rsp_rdata    [2];
   logic        rsp_err      [2];

   logic [7:0]  ref_mem [2][1024];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   data_mem_unit #(.ADDR_WIDTH(AW), .LATENCY(1)) u_lat1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0])
   );

   data_mem_unit #(.ADDR_WIDTH(AW), .LATENCY(3)) u_lat3 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1])
   );

   function automatic int latOf(input int inst);
      return (inst == 0) ? 1 : 3;
   endfunction

   function automatic bit modelErr(input bit [1:0] size, input bit [9:0] addr);
      return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
   endfunction

   // Little-endian byte gather with arithmetic sign extension.
   function automatic logic [31:0] modelLoad(input int inst, input bit [9:0] addr,
                                             input bit [1:0] size, input bit uns);
      longint v = 0;
      int     n = 1 << size;
      for (int i = 0; i < n; i++) v += longint'(ref_mem[inst][int'(addr) + i]) << (8 * i);
      if (!uns && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v -= (64'sd1 << (8 * n));
      return v[31:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int inst, input bit we, input bit [1:0] size,
                                input bit uns, input bit [9:0] addr, input bit [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
      int waited;
      int lat;
      rdata = '0;
      err   = 1'b0;
      @(negedge clk);
      req_valid[inst]    = 1'b1;
      req_we[inst]       = we;
      req_size[inst]     = size;
      req_unsigned[inst] = uns;
      req_addr[inst]     = addr;
      req_wdata[inst]    = wdata;
      waited = 0;
      while (!req_ready[inst] && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready[inst]) begin
         checkOutput("ready_timeout", 32'd0, 32'd1);
         req_valid[inst] = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid[inst] = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid[inst] && lat < 20);
      checkOutput($sformatf("rsp_latency_%0d", inst), 32'(lat), 32'(latOf(inst)));
      rdata = rsp_rdata[inst];
      err   = rsp_err[inst];
      @(negedge clk);
      checkOutput($sformatf("rsp_pulse_%0d", inst), 32'(rsp_valid[inst]), 32'd0);
   endtask

   task automatic runOp(input int inst, input bit we, input bit [1:0] size, input bit uns,
                        input bit [9:0] addr, input bit [31:0] wdata,
                        output logic [31:0] got, output logic gerr);
      bit          e;
      logic [31:0] expv;
      applyStimulus(inst, we, size, uns, addr, wdata, got, gerr);
      e    = modelErr(size, addr);
      expv = '0;
      if (!e && we) begin
         for (int i = 0; i < (1 << size); i++) ref_mem[inst][int'(addr) + i] = 8'(wdata >> (8 * i));
      end else if (!e) begin
         expv = modelLoad(inst, addr, size, uns);
      end
      checkOutput($sformatf("rsp_err_%0d@%03h", inst, addr), 32'(gerr), 32'(e));
      checkOutput($sformatf("rsp_rdata_%0d@%03h", inst, addr), got, expv);
   endtask

   initial begin
      logic [31:0] got;
      logic        gerr;
      logic [9:0]  addrs [4];
      logic [31:0] exp_stream [4];
      int          n_acc;
      bit          acc;

      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'd0;
         req_unsigned[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
      end

      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checkOutput("reset_ready", 32'(req_ready[i]), 32'd0);
         checkOutput("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
         checkOutput("reset_rsp_rdata", rsp_rdata[i], 32'd0);
         checkOutput("reset_rsp_err", 32'(rsp_err[i]), 32'd0);
      end
      rst = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) checkOutput("ready_after_reset", 32'(req_ready[i]), 32'd1);

      for (int i = 0; i < 2; i++)
         for (int w = 0; w < 256; w++) runOp(i, 1'b1, 2'd2, 1'b0, 10'(w * 4), $urandom, got, gerr);

      // Directed LATENCY=1 scenarios
      runOp(0, 1'b1, 2'd2, 1'b0, 10'h10, 32'hDEADBEEF, got, gerr);
      runOp(0, 1'b0, 2'd2, 1'b0, 10'h10, 32'h0, got, gerr);
      checkOutput("word_load", got, 32'hDEADBEEF);
      runOp(0, 1'b1, 2'd2, 1'b0, 10'h20, 32'h0, got, gerr);
      runOp(0, 1'b1, 2'd0, 1'b0, 10'h21, 32'h80, got, gerr);
      runOp(0, 1'b0, 2'd2, 1'b0, 10'h20, 32'h0, got, gerr);
      checkOutput("byte_lane_word", got, 32'h00008000);
      runOp(0, 1'b0, 2'd0, 1'b0, 10'h21, 32'h0, got, gerr);
      checkOutput("byte_signed", got, 32'hFFFFFF80);
      runOp(0, 1'b0, 2'd0, 1'b1, 10'h21, 32'h0, got, gerr);
      checkOutput("byte_unsigned", got, 32'h00000080);
      runOp(0, 1'b1, 2'd1, 1'b0, 10'h22, 32'h8001, got, gerr);
      runOp(0, 1'b0, 2'd1, 1'b0, 10'h22, 32'h0, got, gerr);
      checkOutput("half_signed", got, 32'hFFFF8001);
      runOp(0, 1'b1, 2'd2, 1'b0, 10'h13, 32'h11111111, got, gerr);
      checkOutput("misalign_word_err", 32'(gerr), 32'd1);
      checkOutput("misalign_word_rdata", got, 32'd0);
      runOp(0, 1'b0, 2'd2, 1'b0, 10'h10, 32'h0, got, gerr);
      checkOutput("misalign_no_write", got, 32'hDEADBEEF);
      runOp(0, 1'b0, 2'd1, 1'b0, 10'h11, 32'h0, got, gerr);
      checkOutput("misalign_half_err", 32'(gerr), 32'd1);
      runOp(0, 1'b0, 2'd3, 1'b0, 10'h04, 32'h0, got, gerr);
      checkOutput("illegal_size_err", 32'(gerr), 32'd1);

      // Back-to-back store then load to the same word
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'd2; req_unsigned[0] = 1'b0;
      req_addr[0] = 10'h8; req_wdata[0] = 32'hA5A5A5A5;
      checkOutput("b2b_ready0", 32'(req_ready[0]), 32'd1);
      @(posedge clk);
      #1 req_we[0] = 1'b0;
      for (int i = 0; i < 4; i++) ref_mem[0][8 + i] = 8'hA5;
      @(negedge clk);
      checkOutput("b2b_store_valid", 32'(rsp_valid[0]), 32'd1);
      checkOutput("b2b_store_rdata", rsp_rdata[0], 32'd0);
      checkOutput("b2b_ready1", 32'(req_ready[0]), 32'd1);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(negedge clk);
      checkOutput("b2b_load_valid", 32'(rsp_valid[0]), 32'd1);
      checkOutput("b2b_load_rdata", rsp_rdata[0], 32'hA5A5A5A5);

      // LATENCY=3: four loads with req_valid held high
      for (int i = 0; i < 4; i++) begin
         addrs[i]      = 10'($urandom_range(0, 255) * 4);
         exp_stream[i] = modelLoad(1, addrs[i], 2'd2, 1'b0);
      end
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
      req_addr[1] = addrs[0];
      n_acc = 0;
      for (int c = 0; c <= 12; c++) begin
         checkOutput($sformatf("stream_ready_c%0d", c), 32'(req_ready[1]), 32'(c % 3 == 0));
         if (c > 0) begin
            checkOutput($sformatf("stream_valid_c%0d", c), 32'(rsp_valid[1]), 32'(c % 3 == 0));
            if (c % 3 == 0)
               checkOutput($sformatf("stream_rdata_c%0d", c), rsp_rdata[1], exp_stream[c / 3 - 1]);
         end
         acc = req_ready[1] && req_valid[1];
         @(posedge clk);
         if (acc) begin
            #1;
            n_acc++;
            if (n_acc == 4) req_valid[1] = 1'b0;
            else req_addr[1] = addrs[n_acc];
         end
         @(negedge clk);
      end

      // Reset while a LATENCY=3 store is in flight
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2;
      req_addr[1] = 10'h40; req_wdata[1] = 32'h12345678;
      checkOutput("midrst_ready", 32'(req_ready[1]), 32'd1);
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      for (int i = 0; i < 4; i++) ref_mem[1][16'h40 + i] = 8'(32'h12345678 >> (8 * i));
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("midrst_ready_low", 32'(req_ready[1]), 32'd0);
      checkOutput("midrst_valid", 32'(rsp_valid[1]), 32'd0);
      checkOutput("midrst_rdata", rsp_rdata[1], 32'd0);
      checkOutput("midrst_err", 32'(rsp_err[1]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 checkOutput("midrst_ready_release", 32'(req_ready[1]), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("midrst_no_rsp", 32'(rsp_valid[1]), 32'd0);
      end
      runOp(1, 1'b0, 2'd2, 1'b0, 10'h40, 32'h0, got, gerr);
      checkOutput("midrst_store_kept", got, 32'h12345678);

      // Random traffic on both instances
      for (int k = 0; k < 300; k++) begin
         int         inst;
         int         r;
         bit [1:0]   size;
         bit [9:0]   addr;
         inst = k % 2;
         r    = $urandom_range(0, 9);
         size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         addr = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0 && size != 2'd3) addr = addr & ~10'((1 << size) - 1);
         runOp(inst, 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr,
               $urandom, got, gerr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
